decode_queue: RTL

//  Parametrised decode stage for the MIPS core: a DEPTH-entry instruction buffer feeding a registered decoder.

---
 rtl/decode_queue.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/decode_queue.sv
// decode_queue
//   Decode stage between fetch and the ID/EX register. It holds instructions in
//   a DEPTH-entry circular buffer and decodes the buffer head combinationally.
//   The decoded head is loaded into a registered output stage. A small MDU
//   interlock keeps HILO-using instructions at the head until an issued
//   mul/div has finished.
//
//   Ports
//     clk, resetn        clock, asynchronous active-low reset
//     flush              synchronous flush: drops buffered and output contents
//     in_valid/in_ready  fetch handshake; in_instr/in_pc carry the instruction
//     out_valid/out_ready downstream handshake; out_instr/out_pc registered
//     out_ctrl           {regwrite,regdst,alusrc,branch,memtoreg,jump,is_uimm,
//                         hilo_en[1:0],mov_write,mov_read,mul_div,mem_signed,
//                         mem_we_bhw[3:0],is_jr,is_jalr}
//     out_illegal        instruction not in the decode table (out_ctrl is 0)
//     stall_hilo         head is held by the MDU interlock this cycle
//
//   MDU interlock states
//     state  | meaning
//     S_IDLE | no mul/div outstanding, mdu_cnt is 0
//     S_BUSY | mul/div issued, mdu_cnt counts down the remaining HILO busy cycles
module decode_queue #(
    parameter int DEPTH   = 4,
    parameter int MDU_LAT = 4,
    parameter int PC_W    = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [PC_W-1:0] out_pc,
    output logic [18:0]     out_ctrl,
    output logic            out_illegal,
    output logic            stall_hilo
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int MDU_W = $clog2(MDU_LAT + 1);

    typedef enum logic {S_IDLE, S_BUSY} mdu_state_t;

    logic [31:0]     r_mem_instr [DEPTH];
    logic [PC_W-1:0] r_mem_pc    [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic            r_out_valid;
    logic [31:0]     r_out_instr;
    logic [PC_W-1:0] r_out_pc;
    logic [18:0]     r_out_ctrl;
    logic            r_out_illegal;

    mdu_state_t       r_state, w_state_nxt;
    logic [MDU_W-1:0] r_mdu_cnt, w_mdu_cnt_nxt;

    logic [31:0] w_head_instr;
    logic [5:0]  w_op, w_funct;
    logic        w_empty, w_push, w_load, w_hold;
    logic        w_legal;
    logic [18:0] w_ctrl;

    logic       w_regwrite, w_regdst, w_alusrc, w_branch, w_memtoreg, w_jump, w_is_uimm;
    logic [1:0] w_hilo_en;
    logic       w_mov_write, w_mov_read, w_mul_div, w_mem_signed;
    logic [3:0] w_mem_we_bhw;
    logic       w_is_jr, w_is_jalr;

    assign w_head_instr = r_mem_instr[r_rd_ptr];
    assign w_op         = w_head_instr[31:26];
    assign w_funct      = w_head_instr[5:0];
    assign w_empty      = (r_count == '0);
    assign in_ready     = (r_count != CNT_W'(DEPTH));

    // The interlock only looks at HILO users; everything queued behind a held
    // head waits too because the buffer is strictly in order.
    assign w_hold = !w_empty && (w_hilo_en != 2'b00) && (r_mdu_cnt != '0);
    assign w_push = in_valid && in_ready && !flush;
    assign w_load = !w_empty && (!r_out_valid || out_ready) && !w_hold && !flush;

    // mem_we_bhw = {write, byte, half, word}
    always_comb begin
        w_regwrite   = 1'b0;
        w_regdst     = 1'b0;
        w_alusrc     = 1'b0;
        w_branch     = 1'b0;
        w_memtoreg   = 1'b0;
        w_jump       = 1'b0;
        w_hilo_en    = 2'b00;
        w_mov_write  = 1'b0;
        w_mov_read   = 1'b0;
        w_mul_div    = 1'b0;
        w_mem_signed = 1'b0;
        w_mem_we_bhw = 4'b0000;
        w_is_jr      = 1'b0;
        w_is_jalr    = 1'b0;
        w_legal      = 1'b1;
        case (w_op)
            6'h00: begin
                case (w_funct)
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                    6'h26, 6'h27, 6'h2a, 6'h2b: begin
                        w_regwrite = 1'b1;
                        w_regdst   = 1'b1;
                    end
                    6'h08: w_is_jr = 1'b1;
                    6'h09: begin
                        w_regwrite = 1'b1;
                        w_regdst   = 1'b1;
                        w_is_jalr  = 1'b1;
                    end
                    6'h10, 6'h12: begin
                        w_regwrite = 1'b1;
                        w_regdst   = 1'b1;
                        w_mov_read = 1'b1;
                        w_hilo_en  = (w_funct == 6'h10) ? 2'b10 : 2'b01;
                    end
                    6'h11, 6'h13: begin
                        w_mov_write = 1'b1;
                        w_hilo_en   = (w_funct == 6'h11) ? 2'b10 : 2'b01;
                    end
                    6'h18, 6'h19, 6'h1a, 6'h1b: begin
                        w_mul_div = 1'b1;
                        w_hilo_en = 2'b11;
                    end
                    default: w_legal = 1'b0;
                endcase
            end
            // REGIMM: only the linking forms (rt[4]) write $31
            6'h01: begin
                w_branch   = 1'b1;
                w_regwrite = w_head_instr[20];
            end
            6'h02: w_jump = 1'b1;
            6'h03: begin
                w_jump     = 1'b1;
                w_regwrite = 1'b1;
            end
            6'h04, 6'h05, 6'h06, 6'h07: w_branch = 1'b1;
            6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f: begin
                w_regwrite = 1'b1;
                w_alusrc   = 1'b1;
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                w_regwrite   = 1'b1;
                w_alusrc     = 1'b1;
                w_memtoreg   = 1'b1;
                w_mem_signed = (w_op != 6'h24) && (w_op != 6'h25);
                w_mem_we_bhw = (w_op == 6'h23) ? 4'b0001 :
                               (w_op[0])       ? 4'b0010 : 4'b0100;
            end
            6'h28, 6'h29, 6'h2b: begin
                w_alusrc     = 1'b1;
                w_mem_signed = 1'b1;
                w_mem_we_bhw = (w_op == 6'h2b) ? 4'b1001 :
                               (w_op[0])       ? 4'b1010 : 4'b1100;
            end
            default: w_legal = 1'b0;
        endcase
        w_is_uimm = (w_op[5:2] == 4'b0011);
        w_ctrl = w_legal ? {w_regwrite, w_regdst, w_alusrc, w_branch, w_memtoreg, w_jump,
                            w_is_uimm, w_hilo_en, w_mov_write, w_mov_read, w_mul_div,
                            w_mem_signed, w_mem_we_bhw, w_is_jr, w_is_jalr}
                         : 19'd0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_instr[i] <= '0;
                r_mem_pc[i]    <= '0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem_instr[r_wr_ptr] <= in_instr;
                r_mem_pc[r_wr_ptr]    <= in_pc;
                r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
            end
            if (w_load) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_load) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_load) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_out_valid   <= 1'b0;
            r_out_instr   <= '0;
            r_out_pc      <= '0;
            r_out_ctrl    <= '0;
            r_out_illegal <= 1'b0;
        end else if (flush) begin
            r_out_valid   <= 1'b0;
            r_out_illegal <= 1'b0;
        end else if (w_load) begin
            r_out_valid   <= 1'b1;
            r_out_instr   <= w_head_instr;
            r_out_pc      <= r_mem_pc[r_rd_ptr];
            r_out_ctrl    <= w_ctrl;
            r_out_illegal <= !w_legal;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // mdu_cnt survives a flush: the mul/div has already left for the MDU.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_mdu_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_mdu_cnt <= w_mdu_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_mdu_cnt_nxt = r_mdu_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_load && w_mul_div) begin
                    w_state_nxt   = S_BUSY;
                    w_mdu_cnt_nxt = MDU_W'(MDU_LAT);
                end
            end
            S_BUSY: begin
                w_mdu_cnt_nxt = r_mdu_cnt - MDU_W'(1);
                if (r_mdu_cnt == MDU_W'(1)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_mdu_cnt_nxt = '0;
            end
        endcase
    end

    assign out_valid   = r_out_valid;
    assign out_instr   = r_out_instr;
    assign out_pc      = r_out_pc;
    assign out_ctrl    = r_out_ctrl;
    assign out_illegal = r_out_illegal;
    assign stall_hilo  = w_hold;

endmodule
